// File: rtl/dom_rand_feeder.sv
// Masked-randomness feeder: seeded 32-bit Fibonacci LFSR, RW bits per advance, valid/ready output register.
// Optional reseed-request counter enabled by DOM_RAND_RESEED_REQ_EN.

module dom_rand_step (
  input  logic [31:0] StatexD,
  output logic [31:0] NextxD,
  output logic        BitxD
);
  assign BitxD  = StatexD[31] ^ StatexD[21] ^ StatexD[1] ^ StatexD[0];
  assign NextxD = {StatexD[30:0], BitxD};
endmodule

module dom_rand_feeder #(
  parameter int          SHARES          = 2,
  parameter int          WARMUP          = 4,
  parameter logic [31:0] DEFAULT_SEED    = 32'hACE1F00D,
  parameter int          RESEED_INTERVAL = 1024,
  localparam int         RW              = 4 * SHARES * (SHARES - 1)
) (
  input  logic          ClkxCI,
  input  logic          RstxBI,
  input  logic [31:0]   SeedxDI,
  input  logic          SeedValidxSI,
  output logic [RW-1:0] RandxDO,
  output logic          RandValidxSO,
  input  logic          RandReadyxSI,
  output logic          ReseedReqxSO
);
  typedef enum logic [1:0] {Idle, Warm, Run} state_t;

  localparam logic [7:0] WarmInit = 8'(WARMUP);

  state_t              StatexDP;
  logic [31:0]         LfsrxDP;
  logic [7:0]          WarmxDP;
  logic [RW:0][31:0]   ChainxD;
  logic [RW-1:0]       WordxD;

  // One advance = RW single steps chained; step i contributes word bit i.
  assign ChainxD[0] = LfsrxDP;
  for (genvar i = 0; i < RW; i++) begin : gStep
    dom_rand_step uStep (
      .StatexD(ChainxD[i]),
      .NextxD (ChainxD[i+1]),
      .BitxD  (WordxD[i])
    );
  end

`ifdef DOM_RAND_RESEED_REQ_EN
  localparam logic [15:0] Ivl = 16'(RESEED_INTERVAL);
  logic [15:0] CntxDP;
  logic        ReqxDP;
  assign ReseedReqxSO = ReqxDP;
`else
  localparam int unusedIvl = RESEED_INTERVAL;
  assign ReseedReqxSO = 1'b0;
`endif

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      StatexDP     <= Idle;
      LfsrxDP      <= DEFAULT_SEED;
      WarmxDP      <= '0;
      RandxDO      <= '0;
      RandValidxSO <= 1'b0;
`ifdef DOM_RAND_RESEED_REQ_EN
      CntxDP       <= '0;
      ReqxDP       <= 1'b0;
`endif
    end else if (SeedValidxSI) begin
      // Seed wins over everything, including a same-edge handshake.
      LfsrxDP      <= (SeedxDI == 32'd0) ? DEFAULT_SEED : SeedxDI;
      RandValidxSO <= 1'b0;
      WarmxDP      <= WarmInit;
      StatexDP     <= (WARMUP == 0) ? Run : Warm;
`ifdef DOM_RAND_RESEED_REQ_EN
      CntxDP       <= '0;
      ReqxDP       <= 1'b0;
`endif
    end else begin
      case (StatexDP)
        Warm: begin
          LfsrxDP <= ChainxD[RW];
          WarmxDP <= WarmxDP - 8'd1;
          if (WarmxDP == 8'd1) StatexDP <= Run;
        end
        Run: begin
          if (!RandValidxSO || RandReadyxSI) begin
            LfsrxDP      <= ChainxD[RW];
            RandxDO      <= WordxD;
            RandValidxSO <= 1'b1;
          end
`ifdef DOM_RAND_RESEED_REQ_EN
          if (RandValidxSO && RandReadyxSI && CntxDP != Ivl) begin
            CntxDP <= CntxDP + 16'd1;
            if (CntxDP + 16'd1 == Ivl) ReqxDP <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end
endmodule
